// File: rtl/id_stage.sv
// id_stage: instruction-decode stage with IF/ID register, register file, control decode, sign extend and load-use hazard detection
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   instr_in, pc_in, if_valid    fetched instruction, its PC+4 and valid flag
//   branch_taken                 branch resolved taken in MEM; flushes IF/ID and bubbles controls
//   ex_mem_read, ex_rt           MemRead and rt of the instruction in EX (hazard detection)
//   wb_reg_write, wb_write_reg,
//   wb_write_data                write-back port into the register file
//   stall                        load-use stall; fetch holds PC and instr_in while high
//   EX_out, WB_out, M_out        {RegDst,ALUOp1,ALUOp0,ALUSrc}, {RegWrite,MemtoReg}, {Branch,MemRead,MemWrite}
//   read_data1, read_data2       rs/rt register values with write-through bypass
//   sign_extend                  instr[15:0] sign-extended
//   rt_out, rd_out, pc_out       instr[20:16], instr[15:11], PC+4 of the decoded instruction
module id_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              if_valid,
    input  logic              branch_taken,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic [3:0]        EX_out,
    output logic [1:0]        WB_out,
    output logic [2:0]        M_out,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] sign_extend,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [DATA_W-1:0] pc_out
);
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rf_q [32];
    logic [5:0]        opcode;
    logic [4:0]        rs, rt;
    logic [3:0]        ex_c;
    logic [1:0]        wb_c;
    logic [2:0]        m_c;
    logic              rt_is_src, bubble, wb_hit;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];

    // Flush beats stall; pc_q is left untouched on a flush since it is unused once valid_q drops.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (branch_taken) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = if_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            if (wb_hit) rf_q[wb_write_reg] <= wb_write_data;
        end
    end

    always_comb begin
        ex_c      = '0;
        wb_c      = '0;
        m_c       = '0;
        rt_is_src = 1'b0;
        case (opcode)
            6'b000000: begin ex_c = 4'b1100; wb_c = 2'b10; rt_is_src = 1'b1; end
            6'b100011: begin ex_c = 4'b0001; wb_c = 2'b11; m_c = 3'b010; end
            6'b101011: begin ex_c = 4'b0001; m_c = 3'b001; rt_is_src = 1'b1; end
            6'b000100: begin ex_c = 4'b0010; m_c = 3'b100; rt_is_src = 1'b1; end
            6'b001000: begin ex_c = 4'b0001; wb_c = 2'b10; end
            default: ;
        endcase
    end

    // A branch flush suppresses the stall so the flush is not held off by a dying instruction.
    assign stall = valid_q & ex_mem_read & ~branch_taken & (ex_rt != 5'd0)
                 & ((ex_rt == rs) | ((ex_rt == rt) & rt_is_src));
    assign bubble = ~valid_q | stall | branch_taken;
    assign EX_out = bubble ? '0 : ex_c;
    assign WB_out = bubble ? '0 : wb_c;
    assign M_out  = bubble ? '0 : m_c;

    // Write-through: a same-cycle write-back to the read address is forwarded combinationally.
    assign wb_hit     = wb_reg_write & (wb_write_reg != 5'd0);
    assign read_data1 = (rs == 5'd0) ? '0 : (wb_hit && wb_write_reg == rs) ? wb_write_data : rf_q[rs];
    assign read_data2 = (rt == 5'd0) ? '0 : (wb_hit && wb_write_reg == rt) ? wb_write_data : rf_q[rt];

    assign sign_extend = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign rt_out      = rt;
    assign rd_out      = instr_q[15:11];
    assign pc_out      = pc_q;
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipeline. It sits between instruction fetch and the ID/EX pipeline register and contains:
- the IF/ID pipeline register, with stall and flush;
- the 32x32 register file, with write-through bypass;
- main control decode;
- the sign extender;
- load-use hazard detection.

Its outputs are sampled directly by the ID/EX register on the next rising edge.

## Interface
Parameters:
- DATA_W, 32 (`INTERNAL_BITS): datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_in  in  32  fetched instruction.
- pc_in  in  DATA_W  PC+4 from fetch.
- if_valid  in  1  instr_in/pc_in valid this cycle.
- branch_taken  in  1  branch resolved taken in MEM; flush.
- ex_mem_read  in  1  MemRead of the instruction currently in EX (ID/EX M_out[1]).
- ex_rt  in  5  rt of the instruction in EX (ID/EX Instruction_20_16_out).
- wb_reg_write  in  1  write-back enable.
- wb_write_reg  in  5  write-back destination.
- wb_write_data  in  DATA_W  write-back data.
- stall  out  1  load-use stall; fetch holds PC and instr_in while high.
- EX_out  out  4  {RegDst, ALUOp1, ALUOp0, ALUSrc}.
- WB_out  out  2  {RegWrite, MemtoReg}.
- M_out  out  3  {Branch, MemRead, MemWrite}.
- read_data1, read_data2  out  DATA_W  rs/rt register values.
- sign_extend  out  DATA_W  instr[15:0] sign-extended.
- rt_out, rd_out  out  5  instr[20:16], instr[15:11].
- pc_out  out  DATA_W  PC+4 of the decoded instruction.

## Operation
IF/ID register (instr_q, pc_q, valid_q):
- Reset loads 0/0/0.
- When branch_taken, loads instr_q=0, valid_q=0; pc_q is a don't-care. This wins over stall.
- Holds when stall.
- Otherwise loads instr_in, pc_in, if_valid.

Decode, from opcode instr_q[31:26]:
- 000000 R-type: EX=1100, WB=10, M=000.
- 100011 lw: EX=0001, WB=11, M=010.
- 101011 sw: EX=0001, WB=00 (MemtoReg don't-care driven 0), M=001.
- 000100 beq: EX=0010, WB=00, M=100.
- 001000 addi: EX=0001, WB=10, M=000.
- Any other opcode: all control 0 (NOP).

Bubble: EX/WB/M forced to 0 when any of the following holds:
- valid_q=0;
- stall=1;
- branch_taken=1.

Data outputs are not gated.

Register file:
- 32 x DATA_W.
- Reset clears every entry to 0.
- Write at rising edge when wb_reg_write and wb_write_reg != 0.
- r0 always reads 0.
- Reads are combinational on rs=instr_q[25:21] and rt=instr_q[20:16].
- Bypass: if wb_reg_write and wb_write_reg == read address != 0, the read returns wb_write_data in the same cycle.

Hazard detection (combinational):
- Condition: stall = valid_q & ex_mem_read & ~branch_taken & ex_rt != 0 & (ex_rt == rs | (ex_rt == rt & rt_is_src)).
- rt_is_src is 1 for R-type, sw and beq; 0 otherwise.

Sign extension: sign_extend = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}.

## Timing
- Reset: after a clock edge with rst_n=0, every output reads 0 (stall=0, controls 0, data 0, pc_out 0) until the next valid fetch is captured.
- Reset asserted mid-operation discards the in-flight instruction and clears the register file at that edge.
- Latency: an instruction presented with if_valid at edge n is decoded on the outputs during cycle n+1 and captured by ID/EX at edge n+1.
- A load-use stall lasts exactly one cycle. After the bubble enters ID/EX, ex_mem_read drops and decode proceeds with the held instruction.
- Write-back and read of the same register in the same cycle return the new value.
- A write to r0 has no effect.
- branch_taken and a stall condition in the same cycle:
  - stall=0 and controls are bubbled;
  - IF/ID is flushed at the edge.

## Test plan
- Reset: hold rst_n=0 for 2 edges, then release with if_valid=0 -> all outputs 0, stall=0; reading r1..r31 returns 0.
- Decode and sign-extend:
  - present lw $2,-4($1) (0x8C22FFFC) -> next cycle EX=0001, WB=11, M=010, sign_extend=0xFFFFFFFC, rt_out=2;
  - present beq (0x10220003) -> EX=0010, M=100.
- Write-through bypass: wb_reg_write=1, wb_write_reg=5, wb_write_data=0x12345678 while decoding add $3,$5,$0 -> read_data1=0x12345678 in the same cycle, and still 0x12345678 the following cycle.
- r0 write: wb_write_reg=0, wb_write_data=0xFFFFFFFF -> subsequent read of r0 = 0.
- Load-use: ex_mem_read=1, ex_rt=2, decoding add $4,$2,$3 -> stall=1 and all controls 0 for one cycle, with IF/ID held. Next cycle, with ex_mem_read=0 -> stall=0 and EX=1100, WB=10.
- Flush priority: load-use condition plus branch_taken=1 -> stall=0 and controls 0. After the edge, valid_q=0 and controls stay 0 until a new valid fetch arrives.
